// File: rtl/hist_eq_pkg.sv
// Shared types and sizing helpers for the histogram-equalisation LUT builder.
package hist_eq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIVIDE,
        EMIT,
        DONE
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = $clog2(640 * 480) + 1;
    localparam int DEF_FRAC_W = 24;

    function automatic int calc_num_bins(input int data_w);
        return 1 << data_w;
    endfunction

    // Full num*recip width: nothing may be dropped before the fractional shift.
    function automatic int calc_prod_w(input int cnt_w, input int data_w, input int frac_w);
        return cnt_w + data_w + frac_w;
    endfunction

endpackage

// File: rtl/hist_eq_recip_div.sv
// Serial restoring unsigned divider, one quotient bit per cycle, DVD_W cycles total.
// The first step runs in the i_start cycle; o_done marks the cycle of the final step.
module hist_eq_recip_div #(
    parameter int DVD_W = 32,
    parameter int DSR_W = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DSR_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [DVD_W-1:0] o_quot
);

    localparam int STEP_W = $clog2(DVD_W + 1);

    logic              busy_q, busy_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DVD_W-1:0]  dvd_q, dvd_d, quot_q, quot_d;
    logic [DSR_W-1:0]  dsr_q, dsr_d, rem_q, rem_d;

    logic [DVD_W-1:0]  dvd_cur, quot_cur;
    logic [DSR_W-1:0]  dsr_cur, rem_cur;
    logic [DSR_W:0]    trial;
    logic              ge, step_en;

    always_comb begin
        step_en  = i_start | busy_q;
        dvd_cur  = i_start ? i_dividend : dvd_q;
        dsr_cur  = i_start ? i_divisor  : dsr_q;
        rem_cur  = i_start ? '0 : rem_q;
        quot_cur = i_start ? '0 : quot_q;
        // Remainder is always below the divisor, so the trial fits DSR_W+1 bits.
        trial    = {rem_cur, dvd_cur[DVD_W-1]};
        ge       = trial >= {1'b0, dsr_cur};

        busy_d = busy_q;
        step_d = step_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        if (step_en) begin
            rem_d  = ge ? DSR_W'(trial - {1'b0, dsr_cur}) : trial[DSR_W-1:0];
            dvd_d  = dvd_cur << 1;
            dsr_d  = dsr_cur;
            quot_d = {quot_cur[DVD_W-2:0], ge};
            step_d = i_start ? STEP_W'(1) : step_q + 1'b1;
            busy_d = (step_d != STEP_W'(DVD_W));
        end
        o_done = step_en && (step_d == STEP_W'(DVD_W));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_q <= 1'b0;
            step_q <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    assign o_busy = busy_q;
    assign o_quot = quot_q;

endmodule

// File: rtl/hist_eq_lut_builder.sv
// Streams per-bin counts into a CDF, divides once per frame, then emits the equalisation LUT.
// Define HIST_EQ_ROUND_EN for round-half-up on the final shift; default is truncation.
module hist_eq_lut_builder
    import hist_eq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_bin_valid,
    output logic              o_bin_ready,
    input  logic [CNT_W-1:0]  i_bin_count,
    input  logic              i_lut_ready,
    output logic              o_lut_valid,
    output logic [DATA_W-1:0] o_lut_addr,
    output logic [DATA_W-1:0] o_lut_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_degenerate,
    output logic              o_overflow
);

    localparam int NUM_BINS = calc_num_bins(DATA_W);
    localparam int QW       = DATA_W + FRAC_W;
    localparam int PW       = calc_prod_w(CNT_W, DATA_W, FRAC_W);
    localparam logic [DATA_W-1:0] MAXV     = '1;
    localparam logic [QW-1:0]     DIVIDEND = {MAXV, {FRAC_W{1'b0}}};
`ifdef HIST_EQ_ROUND_EN
    localparam logic [PW:0]       HALF     = (PW + 1)'(1) << (FRAC_W - 1);
`endif

    state_e state_q, state_d;

    logic [CNT_W-1:0]  acc_q, acc_d, cdfmin_q, cdfmin_d;
    logic [CNT_W-1:0]  cdf_q [NUM_BINS];
    logic [CNT_W-1:0]  cdf_d [NUM_BINS];
    logic [DATA_W-1:0] idx_q, idx_d;
    logic              degen_q, degen_d, ovf_q, ovf_d;
    logic [DATA_W:0]   k_q, k_d;
    logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d, s2_data_q, s2_data_d;
    logic [PW-1:0]     s1_prod_q, s1_prod_d;

    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  sat_cdf, denom, num;
    logic [DATA_W-1:0] k_idx, scaled;
    logic [PW:0]       rnd, shifted;
    logic              bin_hs, last_bin, denom_zero, issue, advance, last_beat;
    logic              div_start, div_busy, div_done;
    logic [QW-1:0]     recip;

    assign bin_hs     = (state_q == ACCUM) && i_bin_valid;
    assign last_bin   = bin_hs && (&idx_q);
    assign denom      = acc_q - cdfmin_q;
    assign denom_zero = (denom == '0);
    assign div_start  = (state_q == DIVIDE) && !denom_zero && !div_busy;
    assign issue      = (state_q == EMIT) && !k_q[DATA_W];
    assign advance    = !s2_vld_q || i_lut_ready;
    assign last_beat  = s2_vld_q && i_lut_ready && (&s2_addr_q);
    assign k_idx      = k_q[DATA_W-1:0];

    hist_eq_recip_div #(
        .DVD_W (QW),
        .DSR_W (CNT_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (div_start),
        .i_dividend (DIVIDEND),
        .i_divisor  (denom),
        .o_busy     (div_busy),
        .o_done     (div_done),
        .o_quot     (recip)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ACCUM;
            ACCUM:   if (last_bin) state_d = DIVIDE;
            DIVIDE:  if (denom_zero || div_done) state_d = EMIT;
            EMIT:    if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_bin_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            ACCUM:       begin o_bin_ready = 1'b1; o_busy = 1'b1; end
            DIVIDE, EMIT: o_busy = 1'b1;
            DONE:        o_done = 1'b1;
            default:     ;
        endcase
    end

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, i_bin_count};
        sat_cdf = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        num     = (cdf_q[k_idx] > cdfmin_q) ? cdf_q[k_idx] - cdfmin_q : '0;
`ifdef HIST_EQ_ROUND_EN
        rnd     = {1'b0, s1_prod_q} + HALF;
`else
        rnd     = {1'b0, s1_prod_q};
`endif
        shifted = rnd >> FRAC_W;
        scaled  = (shifted > (PW + 1)'(MAXV)) ? MAXV : shifted[DATA_W-1:0];

        acc_d     = acc_q;
        cdfmin_d  = cdfmin_q;
        cdf_d     = cdf_q;
        idx_d     = idx_q;
        degen_d   = degen_q;
        ovf_d     = ovf_q;
        k_d       = k_q;
        s1_vld_d  = s1_vld_q;
        s1_addr_d = s1_addr_q;
        s1_prod_d = s1_prod_q;
        s2_vld_d  = s2_vld_q;
        s2_addr_d = s2_addr_q;
        s2_data_d = s2_data_q;

        if ((state_q == IDLE) && i_start) begin
            acc_d    = '0;
            cdfmin_d = '0;
            idx_d    = '0;
            degen_d  = 1'b0;
            ovf_d    = 1'b0;
            k_d      = '0;
        end
        if (bin_hs) begin
            acc_d        = sat_cdf;
            cdf_d[idx_q] = sat_cdf;
            idx_d        = idx_q + 1'b1;
            if (sum[CNT_W]) ovf_d = 1'b1;
            // cdfMin is the first non-zero CDF value, so zero means "not seen yet".
            if (cdfmin_q == '0) cdfmin_d = sat_cdf;
        end
        if ((state_q == DIVIDE) && denom_zero) degen_d = 1'b1;

        // Two-stage emit pipeline; a held output beat freezes both stages.
        if (advance) begin
            s1_vld_d  = issue;
            s1_addr_d = k_idx;
            s1_prod_d = PW'(num) * PW'(recip);
            if (issue) k_d = k_q + 1'b1;
            s2_vld_d  = s1_vld_q;
            s2_addr_d = s1_addr_q;
            s2_data_d = degen_q ? s1_addr_q : scaled;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q     <= '0;
            cdfmin_q  <= '0;
            for (int i = 0; i < NUM_BINS; i++) cdf_q[i] <= '0;
            idx_q     <= '0;
            degen_q   <= 1'b0;
            ovf_q     <= 1'b0;
            k_q       <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_prod_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_data_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cdfmin_q  <= cdfmin_d;
            cdf_q     <= cdf_d;
            idx_q     <= idx_d;
            degen_q   <= degen_d;
            ovf_q     <= ovf_d;
            k_q       <= k_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            s1_prod_q <= s1_prod_d;
            s2_vld_q  <= s2_vld_d;
            s2_addr_q <= s2_addr_d;
            s2_data_q <= s2_data_d;
        end
    end

    assign o_lut_valid  = s2_vld_q;
    assign o_lut_addr   = s2_addr_q;
    assign o_lut_data   = s2_data_q;
    assign o_degenerate = degen_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_hist_eq_lut_builder.sv
// Randomised frame-level bench for hist_eq_lut_builder with an arithmetic LUT model.
module tb_hist_eq_lut_builder;

    localparam int DW = 2;
    localparam int CW = 8;
    localparam int FW = 16;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_bin_valid, i_lut_ready;
    logic [CW-1:0] i_bin_count;
    logic          o_bin_ready, o_lut_valid, o_busy, o_done, o_degenerate, o_overflow;
    logic [DW-1:0] o_lut_addr, o_lut_data;

    hist_eq_lut_builder #(.DATA_W(DW), .CNT_W(CW), .FRAC_W(FW)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_bin_valid  (i_bin_valid),
        .o_bin_ready  (o_bin_ready),
        .i_bin_count  (i_bin_count),
        .i_lut_ready  (i_lut_ready),
        .o_lut_valid  (o_lut_valid),
        .o_lut_addr   (o_lut_addr),
        .o_lut_data   (o_lut_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_degenerate (o_degenerate),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] frm_cnt [NB];
    int  ready_mode;
    bit  poke_accum, poke_emit, abort_div;
    int  beat_addr[$];
    int  beat_data[$];
    int  done_pulses, stall_err;
    int  exp_lut [NB];
    bit  exp_degen, exp_ovf;

    // Reference: saturating CDF, first non-zero as cdfMin, integer reciprocal, scaled lookup.
    task automatic model();
        int     cdf [NB];
        int     acc, cmin, total;
        longint recip, v;
        acc = 0; cmin = 0; exp_ovf = 0;
        for (int k = 0; k < NB; k++) begin
            acc += int'(frm_cnt[k]);
            if (acc > 255) begin acc = 255; exp_ovf = 1; end
            cdf[k] = acc;
            if (cmin == 0) cmin = acc;
        end
        total     = acc;
        exp_degen = (total == cmin);
        recip     = exp_degen ? 0 : (longint'(3) << FW) / longint'(total - cmin);
        for (int k = 0; k < NB; k++) begin
            if (exp_degen) exp_lut[k] = k;
            else begin
                v = (cdf[k] > cmin) ? longint'(cdf[k] - cmin) * recip : 0;
`ifdef HIST_EQ_ROUND_EN
                v += longint'(1) << (FW - 1);
`endif
                v = v >> FW;
                exp_lut[k] = (v > 3) ? 3 : int'(v);
            end
        end
    endtask

    task automatic drive_frame();
        int k = 0, cyc = 0, post = 0, h_addr = 0, h_data = 0;
        bit held = 0, saw_done = 0, poked = 0, r;
        beat_addr.delete();
        beat_data.delete();
        done_pulses = 0;
        stall_err   = 0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (k < NB && cyc < 200) begin
            i_bin_valid = ($urandom_range(0, 3) != 0);
            i_bin_count = frm_cnt[k];
            i_start     = poke_accum && (k == 2);
            if (o_bin_ready && i_bin_valid) k++;
            @(negedge clk); cyc++;
        end
        i_bin_valid = 1'b0;
        i_start     = 1'b0;
        if (abort_div) begin
            repeat (5) @(negedge clk);
            #3 i_reset = 1'b1;
            #1;
            return;
        end
        cyc = 0;
        while (post < 3 && cyc < 400) begin
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_lut_ready = r;
            i_start = poke_emit && !poked && o_lut_valid;
            if (i_start) poked = 1;
            if (held && (!o_lut_valid || o_lut_addr != h_addr[DW-1:0] || o_lut_data != h_data[DW-1:0]))
                stall_err++;
            held   = o_lut_valid && !i_lut_ready;
            h_addr = int'(o_lut_addr);
            h_data = int'(o_lut_data);
            if (o_lut_valid && i_lut_ready) begin
                beat_addr.push_back(int'(o_lut_addr));
                beat_data.push_back(int'(o_lut_data));
            end
            if (o_done) begin done_pulses++; saw_done = 1; end
            if (saw_done) post++;
            @(negedge clk); cyc++;
        end
        i_start     = 1'b0;
        i_lut_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 0; i_bin_valid = 0; i_bin_count = '0; i_lut_ready = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_bin_ready, o_lut_valid, o_lut_addr, o_lut_data, o_busy, o_done, o_degenerate, o_overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b addr=%0d data=%0d busy=%b done=%b degen=%b ovf=%b, want all 0",
                     o_bin_ready, o_lut_valid, o_lut_addr, o_lut_data, o_busy, o_done, o_degenerate, o_overflow);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    // Spec frames, backpressure pattern and ignored-start pokes.
    task automatic test_known_frames();
        for (int f = 0; f < 5; f++) begin
            case (f)
                1:       frm_cnt = '{8'd0, 8'd0, 8'd5, 8'd0};
                2:       frm_cnt = '{8'd200, 8'd100, 8'd0, 8'd0};
                default: frm_cnt = '{8'd0, 8'd2, 8'd1, 8'd1};
            endcase
            ready_mode = (f >= 3) ? 1 : (f == 1 ? 2 : 0);
            poke_accum = (f == 4);
            poke_emit  = (f == 4);
            abort_div  = 0;
            model();
            drive_frame();
            n_checks++;
            if (beat_addr.size() != NB) begin
                n_fail++;
                $display("FAIL known%0d_beat_count: got %0d, want %0d", f, beat_addr.size(), NB);
            end
            for (int i = 0; i < beat_addr.size() && i < NB; i++) begin
                n_checks++;
                if (beat_addr[i] != i || beat_data[i] != exp_lut[i]) begin
                    n_fail++;
                    $display("FAIL known%0d_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             f, i, beat_addr[i], beat_data[i], i, exp_lut[i]);
                end
            end
            n_checks++;
            if (o_degenerate !== exp_degen || o_overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL known%0d_flags: got degen=%b ovf=%b, want degen=%b ovf=%b",
                         f, o_degenerate, o_overflow, exp_degen, exp_ovf);
            end
            n_checks++;
            if (done_pulses != 1 || stall_err != 0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL known%0d_done_stall: got done_pulses=%0d stall_err=%0d busy=%b, want 1 0 0",
                         f, done_pulses, stall_err, o_busy);
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        frm_cnt    = '{8'd0, 8'd2, 8'd1, 8'd1};
        ready_mode = 0; poke_accum = 0; poke_emit = 0; abort_div = 1;
        drive_frame();
        n_checks++;
        if ({o_bin_ready, o_lut_valid, o_lut_addr, o_lut_data, o_busy, o_done, o_degenerate, o_overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_divide: got valid=%b busy=%b done=%b degen=%b ovf=%b, want all 0",
                     o_lut_valid, o_busy, o_done, o_degenerate, o_overflow);
        end
        #2 i_reset = 1'b0;
        abort_div = 0;
        model();
        drive_frame();
        n_checks++;
        if (beat_addr.size() != NB || done_pulses != 1) begin
            n_fail++;
            $display("FAIL after_reset_frame: got beats=%0d done_pulses=%0d, want %0d 1",
                     beat_addr.size(), done_pulses, NB);
        end
        for (int i = 0; i < beat_addr.size() && i < NB; i++) begin
            n_checks++;
            if (beat_addr[i] != i || beat_data[i] != exp_lut[i]) begin
                n_fail++;
                $display("FAIL after_reset_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                         i, beat_addr[i], beat_data[i], i, exp_lut[i]);
            end
        end
    endtask

    // Random frames run back to back with random downstream readiness.
    task automatic test_back_to_back();
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < NB; k++)
                frm_cnt[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, (f % 3 == 0) ? 120 : 40));
            ready_mode = 2; poke_accum = 0; poke_emit = 0; abort_div = 0;
            model();
            drive_frame();
            n_checks++;
            if (beat_addr.size() != NB || done_pulses != 1 || stall_err != 0) begin
                n_fail++;
                $display("FAIL rand%0d_stream: got beats=%0d done_pulses=%0d stall_err=%0d, want %0d 1 0",
                         f, beat_addr.size(), done_pulses, stall_err, NB);
            end
            for (int i = 0; i < beat_addr.size() && i < NB; i++) begin
                n_checks++;
                if (beat_addr[i] != i || beat_data[i] != exp_lut[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             f, i, beat_addr[i], beat_data[i], i, exp_lut[i]);
                end
            end
            n_checks++;
            if (o_degenerate !== exp_degen || o_overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL rand%0d_flags: got degen=%b ovf=%b, want degen=%b ovf=%b",
                         f, o_degenerate, o_overflow, exp_degen, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_frames();
        test_reset_mid_divide();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
